// File: rtl/line_window_pkg.sv
// Shared types and helpers for the 3x3 line-window block.
// Window slot numbering is row-major: slot = 3*row + col.
package line_window_pkg;

    localparam int PIX_W_DEFAULT = 12;
    localparam int NUM_TAPS      = 3;

    typedef logic [PIX_W_DEFAULT-1:0] pix_t;

    function automatic int win_slot(input int r, input int c);
        return NUM_TAPS * r + c;
    endfunction

endpackage

// File: rtl/line_delay_en.sv
// Enable-gated pixel delay line.
// q is the sample accepted DEPTH enables ago; async clear empties the line.
module line_delay_en #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1280
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = d;
            for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign q = mem_q[DEPTH-1];

endmodule

// File: rtl/line_window_3x3.sv
// Builds a 3x3 neighbourhood from two chained line delays and emits only
// interior windows, tagged with their centre coordinates.
module line_window_3x3
    import line_window_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int LINE_LEN   = 1280,
    parameter int FRAME_ROWS = 960,
    localparam int COL_W     = $clog2(LINE_LEN),
    localparam int ROW_W     = $clog2(FRAME_ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sof,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_pix,
    output logic               out_valid,
    output logic [9*WIDTH-1:0] out_win,
    output logic [COL_W-1:0]   out_col,
    output logic [ROW_W-1:0]   out_row
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_ROWS - 1);

    // tap[0] is the live pixel, tap[i] is i lines older
    logic [NUM_TAPS-1:0][WIDTH-1:0] tap;
    assign tap[0] = in_pix;

    for (genvar i = 1; i < NUM_TAPS; i++) begin : g_dly
        line_delay_en #(
            .WIDTH (WIDTH),
            .DEPTH (LINE_LEN)
        ) u_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (in_valid),
            .d     (tap[i-1]),
            .q     (tap[i])
        );
    end

    logic [NUM_TAPS-1:0][NUM_TAPS-1:0][WIDTH-1:0] win_q, win_d;
    logic [COL_W-1:0]   col_q, col_d, beat_col;
    logic [ROW_W-1:0]   row_q, row_d, beat_row;
    logic               out_valid_q, out_valid_d;
    logic [9*WIDTH-1:0] out_win_q, out_win_d;
    logic [COL_W-1:0]   out_col_q, out_col_d;
    logic [ROW_W-1:0]   out_row_q, out_row_d;
    logic               qualify;

    // col_q/row_q hold the position the next beat will take unless sof overrides
    always_comb begin
        beat_col = sof ? '0 : col_q;
        beat_row = sof ? '0 : row_q;
        col_d    = col_q;
        row_d    = row_q;
        if (in_valid) begin
            if (beat_col == LAST_COL) begin
                col_d = '0;
                row_d = (beat_row == LAST_ROW) ? '0 : beat_row + ROW_W'(1);
            end else begin
                col_d = beat_col + COL_W'(1);
                row_d = beat_row;
            end
        end
    end

    // Window row r=0 is the oldest line, so it is fed from the deepest tap
    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int r = 0; r < NUM_TAPS; r++) begin
                for (int c = 0; c < NUM_TAPS - 1; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][NUM_TAPS-1] = tap[NUM_TAPS-1-r];
            end
        end
    end

    always_comb begin
        qualify     = in_valid && (beat_col >= COL_W'(2)) && (beat_row >= ROW_W'(2));
        out_valid_d = qualify;
        out_win_d   = out_win_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        if (qualify) begin
            out_col_d = beat_col - COL_W'(1);
            out_row_d = beat_row - ROW_W'(1);
            for (int r = 0; r < NUM_TAPS; r++)
                for (int c = 0; c < NUM_TAPS; c++)
                    out_win_d[win_slot(r, c)*WIDTH +: WIDTH] = win_d[r][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_win_q   <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_win_q   <= out_win_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_win   = out_win_q;
    assign out_col   = out_col_q;
    assign out_row   = out_row_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 on a 4x4 frame with pixel = row*16+col.
module tb_line_window_3x3;

    localparam int W  = 8;
    localparam int LL = 4;
    localparam int FR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sof = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_pix = '0;
    logic          out_valid;
    logic [9*W-1:0] out_win;
    logic [1:0]    out_col;
    logic [1:0]    out_row;

    line_window_3x3 #(.WIDTH(W), .LINE_LEN(LL), .FRAME_ROWS(FR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof       (sof),
        .in_valid  (in_valid),
        .in_pix    (in_pix),
        .out_valid (out_valid),
        .out_win   (out_win),
        .out_col   (out_col),
        .out_row   (out_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           sof;
        logic [7:0]     pix;
        logic           exp_v;
        logic [1:0]     exp_col;
        logic [1:0]     exp_row;
        logic [71:0]    exp_win;
    } vec_t;

    vec_t        vecs [16];
    int          total = 0;
    int          bad = 0;
    int          bc = 0;
    int          br = 0;
    int          n_win = 0;
    logic [71:0] last_win = '0;
    logic [1:0]  last_col = '0;
    logic [1:0]  last_row = '0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected window for a qualifying beat at (c,r) of a clean frame
    function automatic logic [71:0] win_at(input int c, input int r);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[(3*rr+cc)*8 +: 8] = 8'((r - 2 + rr) * 16 + (c - 2 + cc));
        return w;
    endfunction

    task automatic beat(input logic v, input logic s);
        int   c, r;
        logic q;
        if (v && s) begin bc = 0; br = 0; end
        c = bc;
        r = br;
        q = v && c >= 2 && r >= 2;
        in_valid = v;
        sof      = s;
        in_pix   = v ? 8'(r * 16 + c) : 8'hEE;
        if (v) begin
            if (bc == LL - 1) begin
                bc = 0;
                br = (br == FR - 1) ? 0 : br + 1;
            end else begin
                bc = bc + 1;
            end
        end
        @(posedge clk); #1;
        chk("valid", 72'(out_valid), 72'(q));
        if (q) begin
            last_win = win_at(c, r);
            last_col = 2'(c - 1);
            last_row = 2'(r - 1);
            n_win++;
        end
        chk("win", out_win, last_win);
        chk("col", 72'(out_col), 72'(last_col));
        chk("row", 72'(out_row), 72'(last_row));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 72'(out_valid), 72'd0);
        chk({tag, "_win"}, out_win, 72'd0);
        chk({tag, "_col"}, 72'(out_col), 72'd0);
        chk({tag, "_row"}, 72'(out_row), 72'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].sof     = (i == 0);
            vecs[i].pix     = 8'((i / 4) * 16 + (i % 4));
            vecs[i].exp_v   = 1'b0;
            vecs[i].exp_col = '0;
            vecs[i].exp_row = '0;
            vecs[i].exp_win = '0;
        end
        vecs[10].exp_v = 1'b1; vecs[10].exp_col = 2'd1; vecs[10].exp_row = 2'd1;
        vecs[10].exp_win = 72'h22_21_20_12_11_10_02_01_00;
        vecs[11].exp_v = 1'b1; vecs[11].exp_col = 2'd2; vecs[11].exp_row = 2'd1;
        vecs[11].exp_win = 72'h23_22_21_13_12_11_03_02_01;
        vecs[14].exp_v = 1'b1; vecs[14].exp_col = 2'd1; vecs[14].exp_row = 2'd2;
        vecs[14].exp_win = 72'h32_31_30_22_21_20_12_11_10;
        vecs[15].exp_v = 1'b1; vecs[15].exp_col = 2'd2; vecs[15].exp_row = 2'd2;
        vecs[15].exp_win = 72'h33_32_31_23_22_21_13_12_11;

        // Held in reset with traffic on the input
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0];
            sof      = (i == 1);
            in_pix   = 8'(8'h40 + i);
            @(posedge clk); #1;
            chk_zero("rst");
        end
        in_valid = 1'b0;
        sof      = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Continuous frame from the vector table
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            sof      = vecs[i].sof;
            in_pix   = vecs[i].pix;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", i), 72'(out_valid), 72'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                chk($sformatf("tbl%0d_win", i), out_win, vecs[i].exp_win);
                chk($sformatf("tbl%0d_col", i), 72'(out_col), 72'(vecs[i].exp_col));
                chk($sformatf("tbl%0d_row", i), 72'(out_row), 72'(vecs[i].exp_row));
                last_win = vecs[i].exp_win;
                last_col = vecs[i].exp_col;
                last_row = vecs[i].exp_row;
            end
        end
        bc = 0; br = 0;
        beat(1'b0, 1'b0);

        // Idle on every other cycle
        n_win = 0;
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, i == 0);
            beat(1'b0, 1'b0);
        end
        chk("alt_count", 72'(n_win), 72'd4);

        // Random-length idle gaps between beats
        n_win = 0;
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, i == 0);
            repeat ($urandom_range(0, 3)) beat(1'b0, 1'b0);
        end
        chk("burst_count", 72'(n_win), 72'd4);

        // Two back-to-back frames, sof on the first only
        n_win = 0;
        for (int i = 0; i < 32; i++) beat(1'b1, i == 0);
        chk("b2b_count", 72'(n_win), 72'd8);

        // sof arrives where (1,2) would have been
        n_win = 0;
        for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
        chk("midsof_pre", 72'(n_win), 72'd0);
        for (int i = 0; i < 16; i++) beat(1'b1, i == 0);
        chk("midsof_count", 72'(n_win), 72'd4);

        // Reset pulse with the next beat due at (2,3)
        n_win = 0;
        for (int i = 0; i < 14; i++) beat(1'b1, i == 0);
        chk("prerst_count", 72'(n_win), 72'd2);
        in_valid = 1'b0;
        sof      = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_zero("pulse_async");
        @(posedge clk); #1;
        chk_zero("pulse");
        rst_n    = 1'b1;
        bc = 0; br = 0;
        last_win = '0; last_col = '0; last_row = '0;
        n_win = 0;
        for (int i = 0; i < 16; i++) beat(1'b1, 1'b0);
        chk("postrst_count", 72'(n_win), 72'd4);
        beat(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
